// File: rtl/pci_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pci_pkg -- PCI command codes and target state encoding shared by PCI blocks.
// Rev 1.0
// ----------------------------------------------------------------------------
package pci_pkg;

  localparam logic [3:0] CMD_WRITE = 4'b0000;
  localparam logic [3:0] CMD_READ  = 4'b0001;

  typedef enum logic [2:0] {
    TGT_IDLE     = 3'd0,
    TGT_WR_DATA  = 3'd1,
    TGT_RD_TURN  = 3'd2,
    TGT_RD_DATA  = 3'd3,
    TGT_TURN_OFF = 3'd4
  } tgt_state_e;

endpackage
`default_nettype wire

// File: rtl/pci_burst_target_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pci_burst_target_if -- shared PCI bus; tri-state nets resolved from per-side drivers.
// Rev 1.0
// ----------------------------------------------------------------------------
interface pci_burst_target_if #(
  parameter int AD_W = 32
);

  wire  [AD_W-1:0]   AD;
  logic [AD_W/8-1:0] CBE;
  logic              FRAME;
  logic              IRDY;
  wire               DEVSEL;
  wire               TRDY;
  wire               STOP;

  logic [AD_W-1:0]   init_ad;
  logic              init_ad_oe;
  logic [AD_W-1:0]   tgt_ad;
  logic              tgt_ad_oe;
  logic              tgt_devsel;
  logic              tgt_trdy;
  logic              tgt_stop;
  logic              tgt_ctl_oe;

  assign AD     = init_ad_oe ? init_ad : 'z;
  assign AD     = tgt_ad_oe  ? tgt_ad  : 'z;
  assign DEVSEL = tgt_ctl_oe ? tgt_devsel : 1'bz;
  assign TRDY   = tgt_ctl_oe ? tgt_trdy   : 1'bz;
  assign STOP   = tgt_ctl_oe ? tgt_stop   : 1'bz;

  modport master (
    output CBE, FRAME, IRDY, init_ad, init_ad_oe,
    input  AD, DEVSEL, TRDY, STOP
  );

  modport slave (
    input  CBE, FRAME, IRDY, AD,
    output tgt_ad, tgt_ad_oe, tgt_devsel, tgt_trdy, tgt_stop, tgt_ctl_oe
  );

endinterface
`default_nettype wire

// File: rtl/pci_tgt_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pci_tgt_mem -- DEPTH x AD_W word store, byte-enable write, asynchronous read.
// Rev 1.0
// ----------------------------------------------------------------------------
module pci_tgt_mem #(
  parameter int AD_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AD_W/8-1:0]        be_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [AD_W-1:0]          wdata_i,
  output logic [AD_W-1:0]          rdata_o
);

  logic [AD_W-1:0] mem_q [DEPTH];

  // No reset: contents survive a bus reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < AD_W/8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/pci_burst_target.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pci_burst_target -- PCI burst target over a local word memory.
// Rev 1.0; define PCI_TGT_WAIT_STATE_EN for one wait state before the first data phase.
// ----------------------------------------------------------------------------
module pci_burst_target
  import pci_pkg::*;
#(
  parameter int AD_W    = 32,
  parameter int DEPTH   = 16,
  parameter int ID_BITS = 2,
  parameter int DEV_ID  = 0
) (
  input  logic               CLK,
  input  logic               RST,
  pci_burst_target_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
`ifdef PCI_TGT_WAIT_STATE_EN
  localparam logic WAIT_INIT = 1'b1;
`else
  localparam logic WAIT_INIT = 1'b0;
`endif

  localparam logic [2:0] S_IDLE     = TGT_IDLE;
  localparam logic [2:0] S_WR_DATA  = TGT_WR_DATA;
  localparam logic [2:0] S_RD_TURN  = TGT_RD_TURN;
  localparam logic [2:0] S_RD_DATA  = TGT_RD_DATA;
  localparam logic [2:0] S_TURN_OFF = TGT_TURN_OFF;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             wait_q, wait_d;
  logic             disc_q, disc_d;

  logic [3:0]       w_cmd;
  logic             w_claim;
  logic             w_in_data;
  logic             w_trdy_act;
  logic             w_xfer;
  logic [AD_W-1:0]  w_rdata;

  assign w_cmd      = 4'(bus.CBE);
  assign w_claim    = !bus.FRAME && (bus.AD[ID_BITS-1:0] == ID_BITS'(DEV_ID)) &&
                      ((w_cmd == CMD_WRITE) || (w_cmd == CMD_READ));
  assign w_in_data  = (state_q == S_WR_DATA) || (state_q == S_RD_DATA);
  assign w_trdy_act = w_in_data && !wait_q;
  // Once disconnecting, TRDY stays low alongside STOP but nothing more is accepted.
  assign w_xfer     = w_trdy_act && !disc_q && !bus.IRDY;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wait_d  = wait_q;
    disc_d  = disc_q;
    case (state_q)
      S_IDLE: begin
        if (w_claim) begin
          ptr_d  = bus.AD[ID_BITS +: PTR_W];
          disc_d = 1'b0;
          if (w_cmd == CMD_WRITE) begin
            state_d = S_WR_DATA;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = S_RD_TURN;
          end
        end
      end
      S_RD_TURN: begin
        state_d = S_RD_DATA;
        wait_d  = WAIT_INIT;
      end
      S_WR_DATA, S_RD_DATA: begin
        if (wait_q) begin
          wait_d = 1'b0;
        end else if (disc_q) begin
          if (bus.FRAME) state_d = S_TURN_OFF;
        end else if (w_xfer) begin
          if (ptr_q != PTR_LAST) ptr_d = ptr_q + PTR_W'(1);
          if (bus.FRAME)               state_d = S_TURN_OFF;
          else if (ptr_q == PTR_LAST)  disc_d  = 1'b1;
        end
      end
      S_TURN_OFF: begin
        state_d = S_IDLE;
        disc_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wait_q  <= 1'b0;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wait_q  <= wait_d;
      disc_q  <= disc_d;
    end
  end

  pci_tgt_mem #(
    .AD_W  (AD_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (w_xfer && (state_q == S_WR_DATA)),
    .be_i    (bus.CBE),
    .addr_i  (ptr_q),
    .wdata_i (bus.AD),
    .rdata_o (w_rdata)
  );

  // Controls are purely state-decoded so reset floats them without waiting for a clock.
  assign bus.tgt_ctl_oe = (state_q != S_IDLE);
  assign bus.tgt_devsel = (state_q == S_TURN_OFF);
  assign bus.tgt_trdy   = !w_trdy_act;
  assign bus.tgt_stop   = !(disc_q && w_in_data);
  assign bus.tgt_ad_oe  = (state_q == S_RD_DATA);
  assign bus.tgt_ad     = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pci_burst_target.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pci_burst_target -- directed bench for pci_burst_target with a read scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pci_burst_target;
  import pci_pkg::*;

  localparam int AD_W    = 32;
  localparam int DEPTH   = 16;
  localparam int ID_BITS = 2;
  localparam int DEV_ID  = 0;
`ifdef PCI_TGT_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic CLK = 1'b0;
  logic RST;

  pci_burst_target_if #(.AD_W(AD_W)) bus ();

  pci_burst_target #(
    .AD_W    (AD_W),
    .DEPTH   (DEPTH),
    .ID_BITS (ID_BITS),
    .DEV_ID  (DEV_ID)
  ) u_dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          tb_ptr   = 0;
  int          last_waits = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [DEPTH];
  logic [3:0]  exp_first;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // {owned, DEVSEL, TRDY, STOP}; 4'b0000 means the controls are floating.
  function automatic logic [3:0] ctl();
    return bus.tgt_ctl_oe ? {1'b1, bus.DEVSEL, bus.TRDY, bus.STOP} : 4'b0000;
  endfunction

  function automatic logic trdy_on();
    return bus.tgt_ctl_oe && (bus.TRDY === 1'b0);
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.FRAME = 1'b1; bus.IRDY = 1'b1; bus.init_ad_oe = 1'b0;
    bus.init_ad = '0; bus.CBE = '0;
  endtask

  task automatic addr_phase(input logic [3:0] cmd, input int p, input int id);
    bus.FRAME = 1'b0; bus.IRDY = 1'b1; bus.init_ad_oe = 1'b1;
    bus.init_ad = (32'(p) << ID_BITS) | 32'(id);
    bus.CBE = cmd; tb_ptr = p;
    cyc();
  endtask

  task automatic wr_data(input logic [31:0] d, input logic [3:0] be, input logic last);
    int n = 0;
    bus.init_ad_oe = 1'b1; bus.init_ad = d; bus.CBE = be;
    bus.IRDY = 1'b0; bus.FRAME = last;
    while (!trdy_on() && n < 8) begin cyc(); n++; end
    last_waits = n;
    check("wr_trdy", 64'(trdy_on()), 64'd1);
    for (int i = 0; i < 4; i++) if (be[i]) model[tb_ptr][8*i +: 8] = d[8*i +: 8];
    tb_ptr++;
    cyc();
  endtask

  task automatic rd_xfer(input logic last);
    int n = 0;
    bus.init_ad_oe = 1'b0; bus.CBE = 4'hF; bus.IRDY = 1'b0; bus.FRAME = last;
    while (!trdy_on() && n < 8) begin cyc(); n++; end
    last_waits = n;
    check("rd_trdy", 64'(trdy_on()), 64'd1);
    check("rd_ad_oe", 64'(bus.tgt_ad_oe), 64'd1);
    if (exp_q.size() > 0) check("rd_data", bus.AD, exp_q.pop_front());
    else check("rd_sb_empty", 64'(exp_q.size()), 64'd1);
    cyc();
  endtask

  task automatic end_burst(input string tag);
    check({tag, "_turnoff"}, ctl(), 4'b1111);
    check({tag, "_turnoff_ad"}, 64'(bus.tgt_ad_oe), 64'd0);
    idle();
    cyc();
    check({tag, "_release"}, ctl(), 4'b0000);
  endtask

  initial begin
    exp_first = (WS != 0) ? 4'b1011 : 4'b1001;
    RST = 1'b1;
    idle();
    repeat (3) cyc();
    check("rst_ctl", ctl(), 4'b0000);
    check("rst_ad", 64'(bus.tgt_ad_oe), 64'd0);
    check("rst_ptr", 64'(u_dut.ptr_q), 64'd0);
    RST = 1'b0;
    cyc();

    // Three-word write burst from word 0.
    addr_phase(CMD_WRITE, 0, DEV_ID);
    check("wr_first_ctl", ctl(), exp_first);
    wr_data(32'h11111111, 4'hF, 1'b0);
    wr_data(32'h22222222, 4'hF, 1'b0);
    wr_data(32'h33333333, 4'hF, 1'b1);
    end_burst("wr3");
    check("mem0", u_dut.u_mem.mem_q[0], 32'h11111111);
    check("mem1", u_dut.u_mem.mem_q[1], 32'h22222222);
    check("mem2", u_dut.u_mem.mem_q[2], 32'h33333333);

    // Partial byte-enable write over a cleared word.
    addr_phase(CMD_WRITE, 4, DEV_ID);
    wr_data(32'h00000000, 4'hF, 1'b1);
    end_burst("clr4");
    addr_phase(CMD_WRITE, 4, DEV_ID);
    wr_data(32'hAABBCCDD, 4'b0101, 1'b1);
    end_burst("be4");
    check("mem4_merge", u_dut.u_mem.mem_q[4], 32'h00BB00DD);
    check("mem4_model", u_dut.u_mem.mem_q[4], model[4]);

    // Two-word read with a two-cycle initiator wait in the middle.
    addr_phase(CMD_READ, 1, DEV_ID);
    bus.init_ad_oe = 1'b0; bus.IRDY = 1'b1;
    check("rd_turn_ctl", ctl(), 4'b1011);
    check("rd_turn_ad", 64'(bus.tgt_ad_oe), 64'd0);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    rd_xfer(1'b0);
    bus.IRDY = 1'b1;
    for (int k = 0; k < 2; k++) begin
      check("rd_hold", bus.AD, exp_q[0]);
      check("rd_hold_ptr", 64'(u_dut.ptr_q), 64'd2);
      cyc();
    end
    rd_xfer(1'b1);
    end_burst("rd2");
    check("rd_sb_drained", 64'(exp_q.size()), 64'd0);

    // Burst running into the top of memory with FRAME held low.
    addr_phase(CMD_WRITE, DEPTH-2, DEV_ID);
    wr_data(32'hA5A5A5A5, 4'hF, 1'b0);
    wr_data(32'h5A5A5A5A, 4'hF, 1'b0);
    check("disc_ctl", ctl(), 4'b1000);
    bus.init_ad = 32'hFFFFFFFF; bus.IRDY = 1'b0; bus.FRAME = 1'b0;
    cyc();
    check("disc_hold_ctl", ctl(), 4'b1000);
    bus.FRAME = 1'b1;
    cyc();
    end_burst("disc");
    check("mem_top", u_dut.u_mem.mem_q[DEPTH-1], 32'h5A5A5A5A);
    check("mem_top_m1", u_dut.u_mem.mem_q[DEPTH-2], 32'hA5A5A5A5);
    check("mem0_nowrap", u_dut.u_mem.mem_q[0], model[0]);

    // Foreign device id, then an unsupported command.
    addr_phase(CMD_WRITE, 4, 1);
    check("badid_ctl_a", ctl(), 4'b0000);
    bus.init_ad = 32'hDEADBEEF; bus.CBE = 4'hF; bus.IRDY = 1'b0; bus.FRAME = 1'b1;
    cyc();
    check("badid_ctl_d", ctl(), 4'b0000);
    idle(); cyc();
    addr_phase(4'b0110, 4, DEV_ID);
    check("badcmd_ctl_a", ctl(), 4'b0000);
    bus.init_ad = 32'hDEADBEEF; bus.CBE = 4'hF; bus.IRDY = 1'b0; bus.FRAME = 1'b1;
    cyc();
    check("badcmd_ctl_d", ctl(), 4'b0000);
    idle(); cyc();
    check("ignored_mem4", u_dut.u_mem.mem_q[4], 32'h00BB00DD);

    // Reset in the middle of a read data phase, then a clean write.
    addr_phase(CMD_READ, 0, DEV_ID);
    bus.init_ad_oe = 1'b0; bus.IRDY = 1'b1; bus.FRAME = 1'b0;
    begin
      int n = 0;
      while (bus.tgt_ad_oe !== 1'b1 && n < 8) begin cyc(); n++; end
    end
    check("pre_rst_ad", bus.AD, 32'h11111111);
    #2 RST = 1'b1;
    #1;
    check("rst_mid_ctl", ctl(), 4'b0000);
    check("rst_mid_ad", 64'(bus.tgt_ad_oe), 64'd0);
    idle(); cyc();
    RST = 1'b0;
    cyc();
    addr_phase(CMD_WRITE, 0, DEV_ID);
    check("post_rst_first_ctl", ctl(), exp_first);
    wr_data(32'hCAFEF00D, 4'hF, 1'b0);
    check("post_rst_waits", 64'(last_waits), 64'(WS));
    wr_data(32'h0BADBEEF, 4'hF, 1'b1);
    end_burst("post_rst");
    check("post_rst_mem0", u_dut.u_mem.mem_q[0], 32'hCAFEF00D);
    check("post_rst_mem1", u_dut.u_mem.mem_q[1], 32'h0BADBEEF);
    check("post_rst_mem2", u_dut.u_mem.mem_q[2], 32'h33333333);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pci_burst_target.md
PCI_BURST_TARGET -- requirements
Module: pci_burst_target

Interface
REQ-001 Parameter AD_W, default 32, AD bus width in bits; a multiple of 8, 8..64.
REQ-002 Parameter DEPTH, default 16, number of AD_W-bit memory words; a power of two, 2..256.
REQ-003 Parameter ID_BITS, default 2, width of the device-select field AD[ID_BITS-1:0].
REQ-004 Parameter DEV_ID, default 0, value that AD[ID_BITS-1:0] must match to claim a transaction.
REQ-005 Port CLK, input, 1, the single clock; all state changes on posedge CLK.
REQ-006 Port RST, input, 1, reset; asynchronous and active-high.
REQ-007 Port AD, inout, AD_W, multiplexed address/data bus.
REQ-008 Port CBE, input, AD_W/8, command during the address phase, byte enables (1 = byte enabled) during data phases.
REQ-009 Ports FRAME and IRDY, input, 1 each, initiator controls, active-low.
REQ-010 Ports DEVSEL, TRDY and STOP, inout, 1 each, target controls, active-low, driven only while the block owns the transaction, otherwise Z.

Function
REQ-011 Address phase: IDLE and FRAME sampled 0; the block claims only if AD[ID_BITS-1:0]==DEV_ID and CBE[3:0] is 4'b0000 (write) or 4'b0001 (read); all other commands are ignored (stays IDLE).
REQ-012 Start pointer = AD[ID_BITS+log2(DEPTH)-1:ID_BITS], latched in the address phase.
REQ-013 States: IDLE, WR_DATA, RD_TURN, RD_DATA, TURN_OFF.
REQ-014 Write: DEVSEL=0 and TRDY=0 from the edge after the address phase (WR_DATA); AD is never driven.
REQ-015 Transfer = edge with IRDY==0 and TRDY==0; on a write transfer, byte i of mem[ptr] updates only when CBE[i]==1; ptr increments by 1.
REQ-016 Read: RD_TURN for one cycle (DEVSEL=0, TRDY=1, AD=Z); then RD_DATA with AD=mem[ptr] and TRDY=0.
REQ-017 During a read, AD presents the word for the updated ptr on the cycle after each transfer; IRDY=1 holds AD and ptr unchanged (initiator wait).
REQ-018 Transfer with FRAME==1 is the last transfer: next cycle TURN_OFF drives DEVSEL/TRDY/STOP high and AD=Z; the cycle after that, all are Z and the block is IDLE.
REQ-019 Transfer at ptr==DEPTH-1 with FRAME==0: STOP=0 together with TRDY=0 on the next cycle (disconnect-with-data), no further transfer accepted; on FRAME sampled 1, go to TURN_OFF; ptr never wraps.
REQ-020 While not IDLE, a new FRAME falling edge is ignored until TURN_OFF completes.

Reset
REQ-021 RST=1 forces immediately: state IDLE, ptr 0, DEVSEL/TRDY/STOP/AD Z, wait counter 0; no transaction in progress completes.
REQ-022 Reset mid-burst: writes already transferred remain in memory; memory is not cleared by reset (contents undefined after power-up).

Configuration
REQ-023 Macro PCI_TGT_WAIT_STATE_EN defined: one extra cycle with TRDY=1 (DEVSEL=0) before the first data phase of every read and write burst, and AD is valid in that cycle on reads.
REQ-024 Macro PCI_TGT_WAIT_STATE_EN absent: zero-wait timing exactly as REQ-014/REQ-016.

Structure
REQ-025 Package pci_pkg holds the command constants (CMD_WRITE=4'b0000, CMD_READ=4'b0001) and the target state enum; shared with the future master block.
REQ-026 Sub-module pci_tgt_mem: DEPTH x AD_W memory with a byte-enable write port and an asynchronous read port; the state machine and bus drivers sit in pci_burst_target.

Verification
REQ-027 Write burst to DEV_ID, ptr 0, 3 words 0x11111111/0x22222222/0x33333333, CBE=4'hF, FRAME high on the 3rd -> mem[0..2] hold those words; DEVSEL high 1 cycle, then Z.
REQ-028 Write 0xAABBCCDD with CBE=4'b0101 over mem[4]=0 -> mem[4]=0x00BB00DD.
REQ-029 Read burst of 2 from ptr 1 -> AD=0x22222222 then 0x33333333; TRDY high during RD_TURN; IRDY=1 for 2 cycles mid-burst -> AD held and no skipped word.
REQ-030 Write burst starting at ptr DEPTH-2, FRAME kept low -> 2 transfers, STOP=0 on the 2nd; mem[DEPTH-1] written, mem[0] untouched.
REQ-031 Address AD[1:0]!=DEV_ID, or command 4'b0110 -> DEVSEL/TRDY/STOP remain Z for the whole transaction.
REQ-032 RST pulse during a read data phase -> AD and all controls Z in the same cycle; a following write burst to ptr 0 completes normally; repeat with PCI_TGT_WAIT_STATE_EN -> first TRDY=0 one cycle later.
